// File: rtl/ins_decode_q.sv
// Buffered MIPS instruction-decode queue: valid/ready FIFO of {ins, pc} with a
// combinational field split of the head entry. Define DECODE_PERF_EN for pop/stall counters.
module ins_decode_q #(
  parameter int DEPTH = 2,
  parameter int IMM_W = 32,
  parameter int PC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_ins,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        op,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm16,
  output logic [25:0]       imm26,
  output logic [IMM_W-1:0]  imm_ext,
  output logic [PC_W-1:0]   j_target,
  output logic [1:0]        cls,
  output logic [PC_W-1:0]   pc
`ifdef DECODE_PERF_EN
  ,
  output logic [31:0]       dec_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]     ins_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_q  [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            push, pop;
  logic [31:0]     head_ins;

  // No bypass: a full queue refuses input even when the head is leaving this cycle.
  assign in_ready  = (cnt_q != FULL_CNT);
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // NOTE: every variable gets its default at the top of always_comb so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage is reset so the decoded head is never X, even while out_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ins_mem_q[i] <= '0;
        pc_mem_q[i]  <= '0;
      end
    end else if (push) begin
      ins_mem_q[wr_ptr_q] <= in_ins;
      pc_mem_q[wr_ptr_q]  <= in_pc;
    end
  end

  assign head_ins = ins_mem_q[rd_ptr_q];
  assign pc       = pc_mem_q[rd_ptr_q];
  assign op       = head_ins[31:26];
  assign rs       = head_ins[25:21];
  assign rt       = head_ins[20:16];
  assign rd       = head_ins[15:11];
  assign shamt    = head_ins[10:6];
  assign funct    = head_ins[5:0];
  assign imm16    = head_ins[15:0];
  assign imm26    = head_ins[25:0];

  always_comb begin
    case (op)
      6'h00:        cls = 2'b00;
      6'h02, 6'h03: cls = 2'b10;
      default:      cls = 2'b01;
    endcase
  end

  always_comb begin
    case (op)
      6'h0C, 6'h0D, 6'h0E: imm_ext = IMM_W'(imm16);
      6'h0F:               imm_ext = IMM_W'({imm16, 16'h0000});
      default:             imm_ext = {{(IMM_W-16){imm16[15]}}, imm16};
    endcase
  end

  // Only the upper bits of pc+4 are used; they change only when pc[27:2] is all ones.
  logic              p4_carry;
  logic [PC_W-29:0]  p4_hi;
  assign p4_carry = &pc[27:2];
  assign p4_hi    = pc[PC_W-1:28] + (PC_W-28)'(p4_carry);
  assign j_target = {p4_hi, imm26, 2'b00};

`ifdef DECODE_PERF_EN
  logic [31:0] dec_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop)                    dec_cnt_q   <= dec_cnt_q + 32'd1;
      if (out_valid && !out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign dec_cnt   = dec_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ins_decode_q.sv
// Scoreboard bench for ins_decode_q (DEPTH=4): directed decode vectors, backpressure,
// flush, wrap-around streaming and asynchronous reset. Counter checks when DECODE_PERF_EN is defined.
module tb_ins_decode_q;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_ins = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] imm_ext, j_target, pc;
  logic [1:0]  cls;
`ifdef DECODE_PERF_EN
  logic [31:0] dec_cnt, stall_cnt;
`endif

  ins_decode_q #(.DEPTH(DEPTH), .IMM_W(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm16(imm16), .imm26(imm26), .imm_ext(imm_ext), .j_target(j_target),
    .cls(cls), .pc(pc)
`ifdef DECODE_PERF_EN
    , .dec_cnt(dec_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [31:0] imm_ext;
    logic [31:0] j_target;
    logic [1:0]  cls;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_stall = 0;
  int   exp_dec   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t hv(input logic [31:0] ins, input logic [31:0] pcv,
                              input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                              input logic [4:0] d, input logic [4:0] sh, input logic [5:0] f,
                              input logic [31:0] imm, input logic [31:0] j, input logic [1:0] c);
    exp_t e;
    e.ins = ins; e.pc = pcv; e.op = o; e.rs = s; e.rt = t; e.rd = d; e.shamt = sh;
    e.funct = f; e.imm_ext = imm; e.j_target = j; e.cls = c;
    return e;
  endfunction

  // ADDI $0,$0,i at base+4i (i < 64): funct=i, imm_ext=i, j_target=4i.
  function automatic exp_t sv(input int i, input logic [31:0] base);
    logic [31:0] iv;
    iv = 32'(i);
    return hv(32'h2000_0000 | iv, base + 4 * iv, 6'h08, 5'd0, 5'd0, 5'd0, 5'd0,
              iv[5:0], iv, 4 * iv, 2'b01);
  endfunction

  task automatic cmp_head(input exp_t e);
    check("head_op",     op,       e.op);
    check("head_rs",     rs,       e.rs);
    check("head_rt",     rt,       e.rt);
    check("head_rd",     rd,       e.rd);
    check("head_shamt",  shamt,    e.shamt);
    check("head_funct",  funct,    e.funct);
    check("head_imm16",  imm16,    e.ins[15:0]);
    check("head_imm26",  imm26,    e.ins[25:0]);
    check("head_immext", imm_ext,  e.imm_ext);
    check("head_jtgt",   j_target, e.j_target);
    check("head_cls",    cls,      e.cls);
    check("head_pc",     pc,       e.pc);
  endtask

  // Monitor: models occupancy from the scoreboard and compares the head on every pop.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        int n;
        n = sb.size();
        check("out_valid", out_valid, (n != 0));
        check("in_ready",  in_ready,  (n < DEPTH));
        if (n != 0 && !out_ready) exp_stall++;
        if (n != 0 && out_ready && !flush) begin
          cmp_head(sb.pop_front());
          exp_dec++;
        end
        if (in_valid && n < DEPTH && !flush) sb.push_back(cur_exp);
        if (flush) sb.delete();
      end
    end
  end

  // Caller is at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic offer(input exp_t e);
    in_valid = 1'b1; in_ins = e.ins; in_pc = e.pc; cur_exp = e;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("offer_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int c = 0; c < 100 && sb.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    sb.delete(); exp_stall = 0; exp_dec = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_op",        op,        0);
    check("rst_immext",    imm_ext,   0);
    check("rst_jtgt",      j_target,  0);
    check("rst_cls",       cls,       0);
    check("rst_pc",        pc,        0);
`ifdef DECODE_PERF_EN
    check("rst_dec_cnt",   dec_cnt,   0);
    check("rst_stall_cnt", stall_cnt, 0);
`endif

    // Hand-decoded vectors, consumer always ready.
    out_ready = 1'b1;
    offer(hv(32'h2008FFFF, 32'h0040_0000, 6'h08, 5'd0, 5'd8, 5'h1F, 5'h1F, 6'h3F,
             32'hFFFF_FFFF, 32'h0023_FFFC, 2'b01));
    offer(hv(32'h3508FFFF, 32'h0040_0004, 6'h0D, 5'd8, 5'd8, 5'h1F, 5'h1F, 6'h3F,
             32'h0000_FFFF, 32'h0423_FFFC, 2'b01));
    offer(hv(32'h3C081234, 32'h0040_0008, 6'h0F, 5'd0, 5'd8, 5'd2, 5'd8, 6'h34,
             32'h1234_0000, 32'h0020_48D0, 2'b01));
    offer(hv(32'h012A4020, 32'h0040_000C, 6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20,
             32'h0000_4020, 32'h04A9_0080, 2'b00));
    offer(hv(32'h08000010, 32'h4000_0000, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h10,
             32'h0000_0010, 32'h4000_0040, 2'b10));
    drain();

    // Backpressure: fill, hold one more at the input, then release the consumer.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) offer(sv(32 + i, 32'h0000_2000));
    fork
      offer(sv(32 + DEPTH, 32'h0000_2000));
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_full_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_pop_cycle_in_ready", in_ready, 0);
      end
    join
    drain();

    // Flush with an instruction offered in the same cycle.
    out_ready = 1'b0;
    offer(sv(40, 32'h0000_3000));
    offer(sv(41, 32'h0000_3000));
    flush = 1'b1; in_valid = 1'b1;
    cur_exp = sv(42, 32'h0000_3000); in_ins = cur_exp.ins; in_pc = cur_exp.pc;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready",  in_ready,  1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    offer(sv(43, 32'h0000_3000));
    drain();

    // Sixteen entries through pointer wrap with an intermittent consumer.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      out_ready = (i % 3 != 2);
      offer(sv(i, 32'h0000_1000));
    end
    drain();
`ifdef DECODE_PERF_EN
    check("perf_dec_cnt",   dec_cnt,   16);
    check("perf_stall_cnt", stall_cnt, 64'(exp_stall));
`endif

    // Asynchronous reset between clock edges.
    out_ready = 1'b0;
    offer(sv(50, 32'h0000_4000));
    offer(sv(51, 32'h0000_4000));
    @(negedge clk); #2;
    rst = 1'b1;
    sb.delete(); exp_stall = 0; exp_dec = 0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready",  in_ready,  1);
    check("arst_pc",        pc,        0);
    check("arst_op",        op,        0);
`ifdef DECODE_PERF_EN
    check("arst_dec_cnt",   dec_cnt,   0);
    check("arst_stall_cnt", stall_cnt, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
